// File: rtl/jtopl_eg_pkg.sv
// Shared types and helpers for the OPL envelope generator: per-slot phase
// encoding, step pattern bytes and the effective-rate calculation.
package jtopl_eg_pkg;

    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DECAY   = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } eg_state_t;

    localparam logic [7:0] STEP_PAT0 = 8'b10101010;
    localparam logic [7:0] STEP_PAT1 = 8'b11101010;
    localparam logic [7:0] STEP_PAT2 = 8'b11101110;
    localparam logic [7:0] STEP_PAT3 = 8'b11111110;

    function automatic logic [7:0] step_pattern(input logic [1:0] sel);
        logic [7:0] pat;
        unique case (sel)
            2'd0: pat = STEP_PAT0;
            2'd1: pat = STEP_PAT1;
            2'd2: pat = STEP_PAT2;
            2'd3: pat = STEP_PAT3;
        endcase
        return pat;
    endfunction

    // Rate 0 stays 0 (frozen); otherwise 4*R + ks, saturated to 63.
    function automatic logic [5:0] rate_eff(input logic [3:0] r, input logic [3:0] ks);
        logic [6:0] sum;
        sum = {1'b0, r, 2'b00} + {3'b000, ks};
        if (r == 4'd0) return 6'd0;
        return (sum > 7'd63) ? 6'd63 : sum[5:0];
    endfunction

endpackage

// File: rtl/jtopl_eg_calc.sv
// Combinational envelope arithmetic: one attack/decay/release step applied
// to a slot's attenuation for a given effective rate and step bit.
module jtopl_eg_calc
    import jtopl_eg_pkg::*;
#(
    parameter int EGW = 10
) (
    input  eg_state_t        state,
    input  logic             step,
    input  logic [5:0]       rate,
    input  logic [EGW-1:0]   eg_in,
    output logic [EGW-1:0]   eg_next
);

    logic [3:0]     rh;
    logic [EGW:0]   base;
    logic [EGW+1:0] dec;
    logic [3:0]     inc;
    logic [EGW:0]   sum;

    always_comb begin
        rh = rate[5:2];

        case (rh)
            4'd13:        base = ({1'b0, eg_in} >> (EGW-7)) + (EGW+1)'(1);
            4'd14, 4'd15: base = ({1'b0, eg_in} >> (EGW-8)) + (EGW+1)'(1);
            default:      base = ({1'b0, eg_in} >> (EGW-6)) + (EGW+1)'(1);
        endcase

        if (rh > 4'd11)
            dec = step ? {base, 1'b0} : {1'b0, base};
        else if (rh == 4'd11)
            dec = step ? {base, 1'b0} : '0;
        else
            dec = step ? {1'b0, base} : '0;

        case (rh)
            4'd12:   inc = step ? 4'd2 : 4'd1;
            4'd13:   inc = step ? 4'd4 : 4'd2;
            4'd14:   inc = step ? 4'd8 : 4'd4;
            4'd15:   inc = 4'd8;
            default: inc = step ? 4'd2 : 4'd0;
        endcase
        sum = {1'b0, eg_in} + {{(EGW-3){1'b0}}, inc};

        eg_next = eg_in;
        if (rate != 6'd0) begin
            unique case (state)
                ATTACK: begin
                    if (rate[5:1] == 5'h1f || dec >= {2'b00, eg_in})
                        eg_next = '0;
                    else
                        eg_next = eg_in - dec[EGW-1:0];
                end
                DECAY, RELEASE: eg_next = sum[EGW] ? '1 : sum[EGW-1:0];
                SUSTAIN:        eg_next = eg_in;
            endcase
        end
    end

endmodule

// File: rtl/jtopl_eg_mslot.sv
// Time-multiplexed envelope generator: visits one slot per cen, updates its
// ADSR phase and attenuation, and registers the result with its slot index.
module jtopl_eg_mslot
    import jtopl_eg_pkg::*;
#(
    parameter int EGW   = 10,
    parameter int SLOTS = 18,
    parameter int CNTW  = 15
) (
    input  logic                      rst,
    input  logic                      clk,
    input  logic                      cen,
    input  logic                      keyon,
    input  logic [3:0]                ar,
    input  logic [3:0]                dr,
    input  logic [3:0]                rr,
    input  logic [3:0]                sl,
    input  logic [3:0]                ks,
    output logic [$clog2(SLOTS)-1:0]  slot_cnt,
    output logic [EGW-1:0]            eg_out,
    output logic [$clog2(SLOTS)-1:0]  out_slot
);

    localparam int SW = $clog2(SLOTS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS-1);

    logic [EGW-1:0] eg_mem  [SLOTS];
    eg_state_t      st_mem  [SLOTS];
    logic           kon_mem [SLOTS];
    logic [CNTW-1:0] eg_cnt;

    logic [EGW-1:0] cur_eg, eg_new, sl_thr;
    eg_state_t      cur_st, eff_st, nxt_st;
    logic           cur_kon, rise, gate, step;
    logic [3:0]     sel_rate, rh, shamt;
    logic [5:0]     rate, calc_rate;
    logic [7:0]     pat;
    logic [2:0]     idx;
    logic [CNTW-1:0] mask;

    // A rising keyon enters ATTACK and is processed with attack arithmetic
    // in the same visit; that is what lets a fast attack land in DECAY at once.
    always_comb begin
        cur_eg  = eg_mem[slot_cnt];
        cur_st  = st_mem[slot_cnt];
        cur_kon = kon_mem[slot_cnt];
        rise    = keyon & ~cur_kon;
        eff_st  = rise ? ATTACK : (!keyon ? RELEASE : cur_st);

        unique case (eff_st)
            ATTACK:  sel_rate = ar;
            DECAY:   sel_rate = dr;
            SUSTAIN: sel_rate = 4'd0;
            RELEASE: sel_rate = rr;
        endcase
        rate  = rate_eff(sel_rate, ks);
        rh    = rate[5:2];
        shamt = 4'd11 - rh;
        mask  = (CNTW'(1) << shamt) - CNTW'(1);
        pat   = step_pattern(rate[1:0]);
        if (rh >= 4'd12) begin
            gate = 1'b1;
            idx  = eg_cnt[2:0];
        end else begin
            gate = (eg_cnt & mask) == '0;
            idx  = 3'(eg_cnt >> shamt);
        end
        step      = pat[idx];
        calc_rate = gate ? rate : '0;
    end

    jtopl_eg_calc #(.EGW(EGW)) u_calc (
        .state   (eff_st),
        .step    (step),
        .rate    (calc_rate),
        .eg_in   (cur_eg),
        .eg_next (eg_new)
    );

    always_comb begin
        sl_thr = (sl == 4'hf) ? '1 : {sl, {(EGW-4){1'b0}}};
        nxt_st = eff_st;
        if (eff_st == ATTACK && eg_new == '0)
            nxt_st = DECAY;
        else if (eff_st == DECAY && eg_new >= sl_thr)
            nxt_st = SUSTAIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                eg_mem[SW'(i)]  <= '1;
                st_mem[SW'(i)]  <= RELEASE;
                kon_mem[SW'(i)] <= 1'b0;
            end
            slot_cnt <= '0;
            out_slot <= '0;
            eg_out   <= '1;
            eg_cnt   <= '0;
        end else if (cen) begin
            eg_mem[slot_cnt]  <= eg_new;
            st_mem[slot_cnt]  <= nxt_st;
            kon_mem[slot_cnt] <= keyon;
            eg_out            <= eg_new;
            out_slot          <= slot_cnt;
            if (slot_cnt == LAST_SLOT) begin
                slot_cnt <= '0;
                eg_cnt   <= eg_cnt + CNTW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_jtopl_eg_mslot.sv
// Self-checking bench for jtopl_eg_mslot: table vectors on slot 0, directed
// corner sequences and randomized traffic against an arithmetic slot model.
module tb_jtopl_eg_mslot;

    localparam int NS = 18;
    localparam int ST_A = 0, ST_D = 1, ST_S = 2, ST_R = 3;

    logic       rst, clk, cen, keyon;
    logic [3:0] ar, dr, rr, sl, ks;
    logic [4:0] slot_cnt, out_slot;
    logic [9:0] eg_out;

    jtopl_eg_mslot #(.EGW(10), .SLOTS(18), .CNTW(15)) dut (
        .rst(rst), .clk(clk), .cen(cen), .keyon(keyon),
        .ar(ar), .dr(dr), .rr(rr), .sl(sl), .ks(ks),
        .slot_cnt(slot_cnt), .eg_out(eg_out), .out_slot(out_slot)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // per-slot stimulus
    bit         t_kon [NS];
    logic [3:0] t_ar [NS], t_dr [NS], t_rr [NS], t_sl [NS], t_ks [NS];

    // reference model state
    int m_eg [NS], m_st [NS], m_prev [NS];
    int m_cnt, tb_slot, last_eg, last_slot;
    int PAT [4] = '{8'hAA, 8'hEA, 8'hEE, 8'hFE};

    typedef struct {
        bit kon;
        int ar, dr, rr, sl, ks;
        int eg;
    } vec_t;
    vec_t vt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_eg[i] = 1023; m_st[i] = ST_R; m_prev[i] = 0;
        end
        m_cnt = 0; tb_slot = 0; last_eg = 1023; last_slot = 0;
    endtask

    task automatic model_visit(input int s, output int e_out);
        int st, r, rate, rh, per, idx, step, e, sh, base, d, inc, thr;
        bit rise, upd;
        rise = t_kon[s] && (m_prev[s] == 0);
        st = rise ? ST_A : (!t_kon[s] ? ST_R : m_st[s]);
        r = (st == ST_A) ? int'(t_ar[s]) : (st == ST_D) ? int'(t_dr[s]) :
            (st == ST_R) ? int'(t_rr[s]) : 0;
        rate = (r == 0) ? 0 : ((r*4 + int'(t_ks[s]) > 63) ? 63 : r*4 + int'(t_ks[s]));
        rh = rate / 4;
        if (rh < 12) begin
            per = 1 << (11 - rh);
            upd = (m_cnt % per) == 0;
            idx = (m_cnt / per) % 8;
        end else begin
            upd = 1;
            idx = m_cnt % 8;
        end
        step = (PAT[rate % 4] >> idx) & 1;
        e = m_eg[s];
        if (rate != 0 && upd) begin
            if (st == ST_A) begin
                if (rate >= 62) e = 0;
                else begin
                    sh = (rh == 13) ? 3 : (rh >= 14) ? 2 : 4;
                    base = (e >> sh) + 1;
                    if (rh > 11)       d = step ? 2*base : base;
                    else if (rh == 11) d = step ? 2*base : 0;
                    else               d = step ? base : 0;
                    e = e - d;
                    if (e < 0) e = 0;
                end
            end else if (st == ST_D || st == ST_R) begin
                case (rh)
                    12: inc = step ? 2 : 1;
                    13: inc = step ? 4 : 2;
                    14: inc = step ? 8 : 4;
                    15: inc = 8;
                    default: inc = step ? 2 : 0;
                endcase
                e = e + inc;
                if (e > 1023) e = 1023;
            end
        end
        thr = (t_sl[s] == 15) ? 1023 : int'(t_sl[s]) * 64;
        if (st == ST_A && e == 0) st = ST_D;
        else if (st == ST_D && e >= thr) st = ST_S;
        m_eg[s] = e; m_st[s] = st; m_prev[s] = t_kon[s] ? 1 : 0;
        e_out = e;
        if (s == NS-1) m_cnt = (m_cnt + 1) % 32768;
    endtask

    task automatic tick(output int e_exp, output int e_act);
        int s;
        s = tb_slot;
        keyon = t_kon[s]; ar = t_ar[s]; dr = t_dr[s]; rr = t_rr[s];
        sl = t_sl[s]; ks = t_ks[s];
        @(posedge clk); #1;
        model_visit(s, e_exp);
        e_act = int'(eg_out);
        check("eg_out", 32'(eg_out), e_exp);
        check("out_slot", 32'(out_slot), s);
        last_eg = e_exp; last_slot = s;
        tb_slot = (s + 1) % NS;
    endtask

    task automatic round(output int e0);
        int e, a;
        e0 = -1;
        for (int i = 0; i < NS; i++) begin
            tick(e, a);
            if (i == 0) e0 = a;
        end
    endtask

    task automatic pulse_reset();
        #2 rst = 1;
        #1;
        check("rst_eg_out", 32'(eg_out), 32'h3ff);
        check("rst_out_slot", 32'(out_slot), 0);
        check("rst_slot_cnt", 32'(slot_cnt), 0);
        @(posedge clk); #2 rst = 0;
        model_reset();
    endtask

    initial begin
        int e0, e, a;
        clk = 0; rst = 0; cen = 1; keyon = 0;
        ar = 0; dr = 0; rr = 0; sl = 0; ks = 0;
        for (int i = 0; i < NS; i++) begin
            t_kon[i] = 0; t_ar[i] = 0; t_dr[i] = 0; t_rr[i] = 0; t_sl[i] = 0; t_ks[i] = 0;
        end
        vt[0] = '{1, 15, 0, 0, 1, 15, 0};
        for (int i = 1; i <= 8; i++) vt[i] = '{1, 15, 15, 0, 1, 15, 8*i};
        vt[9]  = '{1, 15, 15, 0, 1, 15, 64};
        vt[10] = '{0, 15, 15, 15, 1, 15, 72};
        vt[11] = '{0, 15, 15, 15, 1, 15, 80};
        vt[12] = '{0, 15, 15, 0, 1, 15, 80};
        vt[13] = '{1, 15, 0, 0, 1, 15, 0};
        vt[14] = '{1, 15, 0, 0, 1, 15, 0};
        vt[15] = '{1, 15, 4, 0, 1, 0, 0};
        model_reset();

        #2 rst = 1;
        #1;
        check("reset_eg_out", 32'(eg_out), 32'h3ff);
        check("reset_out_slot", 32'(out_slot), 0);
        check("reset_slot_cnt", 32'(slot_cnt), 0);
        @(posedge clk); @(posedge clk); #2 rst = 0;

        // two idle rounds
        for (int i = 0; i < 2*NS; i++) tick(e, a);
        check("eg_cnt_after_36", 32'(dut.eg_cnt), 2);

        // slot 0 table vectors, one visit per round
        for (int i = 0; i < 16; i++) begin
            t_kon[0] = vt[i].kon; t_ar[0] = 4'(vt[i].ar); t_dr[0] = 4'(vt[i].dr);
            t_rr[0] = 4'(vt[i].rr); t_sl[0] = 4'(vt[i].sl); t_ks[0] = 4'(vt[i].ks);
            round(e0);
            check($sformatf("vec%0d", i), 32'(e0), 32'(vt[i].eg));
            if (i == 0) check("state_decay", 32'(dut.st_mem[0]), 1);
            if (i == 9) check("state_sustain", 32'(dut.st_mem[0]), 2);
        end

        // keyon with frozen attack from silence
        pulse_reset();
        t_kon[0] = 1; t_ar[0] = 0; t_dr[0] = 0; t_rr[0] = 0; t_sl[0] = 0; t_ks[0] = 0;
        for (int r = 0; r < 100; r++) begin
            round(e0);
            if (r % 25 == 0 || r == 99) check("ar0_hold", 32'(e0), 32'h3ff);
        end

        // decay to 0x3F8, then release saturates
        t_ar[0] = 15; t_ks[0] = 15;
        round(e0);
        check("attack_to_zero", 32'(e0), 0);
        t_dr[0] = 15; t_sl[0] = 15;
        for (int r = 0; r < 127; r++) round(e0);
        check("decay_3f8", 32'(e0), 32'h3f8);
        t_kon[0] = 0; t_rr[0] = 15;
        round(e0);
        check("release_sat", 32'(e0), 32'h3ff);
        for (int r = 0; r < 3; r++) round(e0);
        check("release_held", 32'(e0), 32'h3ff);

        // park slot 0 in ATTACK at 0x200, then reset mid-round
        t_kon[0] = 1; t_ar[0] = 15;
        round(e0);
        for (int r = 0; r < 64; r++) round(e0);
        check("decay_200", 32'(e0), 32'h200);
        t_kon[0] = 0; t_rr[0] = 0;
        round(e0);
        t_kon[0] = 1; t_ar[0] = 0;
        round(e0);
        check("attack_200", 32'(e0), 32'h200);
        check("state_attack", 32'(dut.st_mem[0]), 0);
        for (int i = 0; i < 5; i++) tick(e, a);
        pulse_reset();
        t_kon[0] = 0;
        tick(e, a);
        check("post_rst_slot0", 32'(out_slot), 0);
        check("post_rst_eg", 32'(eg_out), 32'h3ff);

        // cen low holds everything
        cen = 0;
        keyon = 1; ar = 4'hf; ks = 4'hf;
        repeat (4) @(posedge clk);
        #1;
        check("cen_hold_eg", 32'(eg_out), 32'(last_eg));
        check("cen_hold_slot", 32'(out_slot), 32'(last_slot));
        check("cen_hold_cnt", 32'(slot_cnt), 32'(tb_slot));
        cen = 1;

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            int s;
            s = tb_slot;
            if ($urandom_range(0, 5) == 0) t_kon[s] = !t_kon[s];
            if ($urandom_range(0, 3) == 0) begin
                t_ar[s] = 4'($urandom_range(0, 15)); t_dr[s] = 4'($urandom_range(0, 15));
                t_rr[s] = 4'($urandom_range(0, 15)); t_sl[s] = 4'($urandom_range(0, 15));
                t_ks[s] = 4'($urandom_range(0, 15));
            end
            tick(e, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
